// File: rtl/layer4_fc_if.sv
// Bus between the layer-3 ping-pong buffer / weight ROM and the layer-4 FC stage.
interface layer4_fc_if #(parameter int N_OUT = 84);
  logic                    in_valid;
  logic signed [15:0]      in_data;
  logic [6:0]              in_addr;
  logic [6:0]              w_addr;
  logic [N_OUT*16-1:0]     w_data;
  logic [N_OUT*16-1:0]     bias;
  logic [N_OUT*16-1:0]     dout;
  logic                    done;
  logic                    busy;
  logic                    frame_err;

  modport master (output in_valid, in_data, in_addr, w_data, bias,
                  input  w_addr, dout, done, busy, frame_err);
  modport slave  (input  in_valid, in_data, in_addr, w_data, bias,
                  output w_addr, dout, done, busy, frame_err);
endinterface

// File: rtl/layer4_fc.sv
// Layer-4 fully connected stage: serial feature stream into N_OUT parallel MAC lanes.
// Optional ReLU on the outputs is enabled by defining LAYER4_RELU_EN.
module layer4_fc_lane #(
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v1_i,
  input  logic               first_i,
  input  logic               v2_i,
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] w_i,
  input  logic signed [15:0] b_i,
  output logic [15:0]        y_o
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_d, acc_q, r;
  logic signed [15:0]      sat;
  logic [15:0]             y_d, y_q;

  assign prod     = 32'(x_i) * 32'(w_i);
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign bias_ext = {{(ACC_W-16){b_i[15]}}, b_i};
  assign r        = acc_q >>> FRAC;

  always_comb begin
    acc_d = acc_q;
    if (v1_i) acc_d = first_i ? (bias_ext <<< FRAC) + prod_ext : acc_q + prod_ext;
    if (r > MAXV)      sat = 16'sh7fff;
    else if (r < MINV) sat = -16'sh8000;
    else               sat = r[15:0];
    y_d = y_q;
`ifdef LAYER4_RELU_EN
    if (v2_i) y_d = sat[15] ? 16'h0000 : sat;
`else
    if (v2_i) y_d = sat;
`endif
  end

  // Output samples acc_q on the same edge a back-to-back first-load overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module layer4_fc #(
  parameter int N_IN  = 120,
  parameter int N_OUT = 84,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic clk,
  input  logic rst,
  layer4_fc_if.slave bus
);
  logic                    accept, is_first, is_last;
  logic signed [15:0]      x_q;
  logic                    first_q, last_q, v1_q, v2_q, done_q, busy_q;
  logic                    err_d, err_q, open_d, open_q;
  logic [6:0]              exp_d, exp_q;
  logic [N_OUT-1:0][15:0]  y;

  assign bus.w_addr = rst ? 7'd0 : bus.in_addr;
  assign accept     = bus.in_valid && (int'(bus.in_addr) < N_IN);
  assign is_first   = (bus.in_addr == 7'd0);
  assign is_last    = (bus.in_addr == 7'(N_IN-1));

  // open_q tracks frame occupancy at the input edge, one stage ahead of busy,
  // so an addr-0 beat right after addr-(N_IN-1) is not flagged as a restart.
  always_comb begin
    exp_d  = exp_q;
    open_d = open_q;
    err_d  = err_q;
    if (accept) begin
      if (is_first) begin
        exp_d = (N_IN == 1) ? 7'd0 : 7'd1;
        if (open_q) err_d = 1'b1;
      end else begin
        if (bus.in_addr != exp_q) err_d = 1'b1;
        exp_d = (exp_q == 7'(N_IN-1)) ? 7'd0 : exp_q + 7'd1;
      end
      open_d = !is_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      open_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      x_q     <= bus.in_data;
      first_q <= is_first;
      last_q  <= is_last;
      v1_q    <= accept;
      v2_q    <= v1_q && last_q;
      done_q  <= v2_q;
      err_q   <= err_d;
      open_q  <= open_d;
      exp_q   <= exp_d;
      if (v1_q) begin
        if (last_q)       busy_q <= 1'b0;
        else if (first_q) busy_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    layer4_fc_lane #(.FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .v1_i    (v1_q),
      .first_i (first_q),
      .v2_i    (v2_q),
      .x_i     (x_q),
      .w_i     (bus.w_data[i*16 +: 16]),
      .b_i     (bus.bias[i*16 +: 16]),
      .y_o     (y[i])
    );
  end

  assign bus.dout      = y;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_layer4_fc.sv
// Directed bench for layer4_fc: uniform-weight ROM model, hand-computed lane results.
module tb_layer4_fc;
  localparam int N_IN  = 120;
  localparam int N_OUT = 84;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic signed [15:0] w_val  = 16'sd256;
  logic signed [15:0] w0_val = 16'sd256;
  int   done_cyc[$];
  logic [15:0] done_l0[$];

  layer4_fc_if #(.N_OUT(N_OUT)) bus ();

  layer4_fc #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(8), .ACC_W(40)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // weight ROM model: one-cycle registered read, row content uniform per test
  always @(posedge clk)
    for (int i = 0; i < N_OUT; i++)
      bus.w_data[i*16 +: 16] <= (i == 0) ? w0_val : w_val;

  always @(negedge clk)
    if (bus.done) begin
      done_cyc.push_back(cyc);
      done_l0.push_back(bus.dout[15:0]);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int i);
    return bus.dout[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input logic signed [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = 7'(a);
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input logic signed [15:0] d);
    for (int a = 0; a < N_IN; a++) beat(a, d);
  endtask

  task automatic set_bias(input logic signed [15:0] b);
    for (int i = 0; i < N_OUT; i++) bus.bias[i*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_out();
    repeat (4) tick();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_addr  = 7'd37;
    bus.in_data  = '0;
    set_bias(16'sd0);
    tick();
    chk("rst_w_addr", 32'(bus.w_addr), 32'd0);
    chk("rst_dout0", 32'(lane(0)), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("w_addr_pass", 32'(bus.w_addr), 32'd37);

    // basic frame: 1.0*1.0*120 = 120.0 -> 30720, done 3 edges after last beat
    done_cyc.delete(); done_l0.delete();
    frame(16'sd256);
    chk("t1_done_e1", 32'(bus.done), 32'd0);
    tick();
    chk("t1_done_e2", 32'(bus.done), 32'd0);
    tick();
    chk("t1_done_e3", 32'(bus.done), 32'd1);
    chk("t1_lane0", 32'(lane(0)), 32'd30720);
    chk("t1_lane41", 32'(lane(41)), 32'd30720);
    chk("t1_lane83", 32'(lane(83)), 32'd30720);
    tick();
    chk("t1_done_e4", 32'(bus.done), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_err", 32'(bus.frame_err), 32'd0);

    // saturation: 240.0 exceeds Q8.8 range
    w_val = 16'sd512; w0_val = 16'sd512;
    frame(16'sd256);
    wait_out();
    chk("t2_lane0_sat", 32'(lane(0)), 32'd32767);
    chk("t2_lane83_sat", 32'(lane(83)), 32'd32767);

    // negative lane: 1.0 - 120.0 = -119.0 -> -30464; other lanes 121.0
    w_val = 16'sd256; w0_val = -16'sd256;
    set_bias(16'sd256);
    frame(16'sd256);
    wait_out();
`ifdef LAYER4_RELU_EN
    chk("t3_lane0_relu", 32'(lane(0)), 32'h0000);
`else
    chk("t3_lane0_neg", 32'(lane(0)), 32'h8900);
`endif
    chk("t3_lane1", 32'(lane(1)), 32'd30976);

    // back-to-back frames, no gap
    w0_val = 16'sd256;
    set_bias(16'sd0);
    done_cyc.delete(); done_l0.delete();
    frame(16'sd256);
    frame(16'sd128);
    wait_out();
    chk("t4_done_cnt", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) begin
      chk("t4_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd120);
      chk("t4_first", 32'(done_l0[0]), 32'd30720);
      chk("t4_second", 32'(done_l0[1]), 32'd15360);
    end
    chk("t4_lane83", 32'(lane(83)), 32'd15360);
    chk("t4_err", 32'(bus.frame_err), 32'd0);

    // skipped index 50
    do_reset();
    done_cyc.delete(); done_l0.delete();
    for (int a = 0; a < 50; a++) beat(a, 16'sd256);
    chk("t5_err_pre", 32'(bus.frame_err), 32'd0);
    beat(51, 16'sd256);
    chk("t5_err_set", 32'(bus.frame_err), 32'd1);
    for (int a = 52; a < N_IN; a++) beat(a, 16'sd256);
    wait_out();
    chk("t5_err_sticky", 32'(bus.frame_err), 32'd1);
    chk("t5_done_cnt", 32'(done_cyc.size()), 32'd1);

    // reset mid-frame, then clean frame
    do_reset();
    done_cyc.delete(); done_l0.delete();
    for (int a = 0; a <= 60; a++) beat(a, 16'sd256);
    tick();
    chk("t6_busy_mid", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy_rst", 32'(bus.busy), 32'd0);
    chk("t6_err_rst", 32'(bus.frame_err), 32'd0);
    tick();
    rst = 1'b0;
    wait_out();
    chk("t6_no_done", 32'(done_cyc.size()), 32'd0);
    frame(16'sd256);
    wait_out();
    chk("t6_done_cnt", 32'(done_cyc.size()), 32'd1);
    chk("t6_lane0", 32'(lane(0)), 32'd30720);
    chk("t6_lane60", 32'(lane(60)), 32'd30720);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_err", 32'(bus.frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/layer4_fc.md
Name: layer4_fc

Overview:
- Fully connected stage directly downstream of the layer-3 ping-pong buffer.
- Consumes the serial 120-element feature stream (one 16-bit signed value per cycle, tagged with its index). Accumulates into N_OUT parallel neurons using one weight row per input index.
- After the last element, emits the packed N_OUT-lane result vector with a one-cycle done pulse for layer 5.

Parameters:
- N_IN, 120, inputs per frame; the in_addr range is 0..N_IN-1.
- N_OUT, 84, output neurons, i.e. parallel MAC lanes.
- FRAC, 8, fractional bits of the Q-format shared by data, weights and bias.
- ACC_W, 40, accumulator width per lane (signed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid; the upstream enable strobe.
- in_data  in  16  signed input value.
- in_addr  in  7  index of in_data within the frame.
- w_addr  out  7  weight ROM row address.
- w_data  in  N_OUT*16  weight row; lane i in bits [i*16 +: 16]; 1-cycle synchronous ROM latency.
- bias  in  N_OUT*16  per-lane signed bias, quasi-static, lane packing as w_data.
- dout  out  N_OUT*16  result vector, same lane packing.
- done  out  1  one-cycle pulse when dout is updated.
- busy  out  1  high while a frame is partially accumulated.
- frame_err  out  1  sticky sequence-error flag.

Behaviour:
- Reset (async, immediate) clears: dout=0, done=0, busy=0, frame_err=0, w_addr=0, all accumulators, all pipeline valids, expected index=0.
- w_addr = in_addr, combinational pass-through. The ROM returns the row on the next cycle.
- Stage 1 (edge after beat): register x=in_data, first=(in_addr==0), last=(in_addr==N_IN-1), v1=in_valid & (in_addr<N_IN).
  - Beats with in_addr>=N_IN are dropped (v1=0).
- Stage 2 (next edge, when v1): per lane, prod = x*w_data lane, 32-bit signed.
  - If first: acc <= sext(bias)<<FRAC + sext(prod).
  - Else: acc <= acc + sext(prod).
  - Register last into v2.
- Output stage (next edge, when v2), per lane:
  - r = acc >>> FRAC (arithmetic shift).
  - Saturate r to [-32768, 32767].
  - Apply optional ReLU.
  - Write dout; done=1 for exactly this cycle, else 0.
- Latency: beat with in_addr=N_IN-1 at edge k → done high after edge k+3.
- Back-to-back frames: an addr-0 beat may immediately follow the addr-(N_IN-1) beat.
  - The output stage samples acc before the new frame's first-load overwrites it; no bubble is required.
  - dout holds until the next done.
- busy: set by an accepted stage-2 first, cleared by stage-2 last. A first and a last in the same beat (only when N_IN=1) leave busy=0.
- Sequence check: an expected-index counter advances on each accepted beat and wraps to 0 after N_IN-1.
  - A beat with in_addr==0 always resynchronises the counter; this is the restart of a partial frame. It sets frame_err only if busy.
  - A beat whose in_addr differs from the expected index and is nonzero sets frame_err. The beat is still accumulated.
  - frame_err clears only on rst.
- Reset mid-frame: the partial frame is discarded and no done is issued. The next frame must start at addr 0.
- Widths: ACC_W must be at least 32+ceil(log2(N_IN))+1. With the default 40 there is no accumulator overflow.

Optional Feature:
- LAYER4_RELU_EN.
  - Defined: after saturation, negative lanes are forced to 0 (dout lanes are always >= 0).
  - Undefined: the saturated signed value passes through unchanged.

Test Plan:
- All in_data=256, all weights=256, bias=0, addr 0..119 consecutive → every dout lane=30720; done high exactly 3 cycles after the addr-119 beat; frame_err=0.
- Weights=512, data=256, bias=0 → lane value 61440 saturates → every lane=32767.
- Lane 0 weights=-256, data=256, bias=256 → r=-30464. With LAYER4_RELU_EN → lane0=0. Without → lane0=-30464 (0x8900).
- Two frames back-to-back with no gap, the second using data=128 with the same 256 weights → two done pulses 120 cycles apart; second dout lanes=15360; first result not corrupted.
- Frame sent as 0..49 then 51..119 → frame_err=1 after the addr-51 beat and stays 1; done still pulses.
- rst pulsed at addr 60, then a clean frame → no done for the aborted frame; the clean frame gives the correct 30720 result; busy=0 after reset.
